// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the FemtoRV32 peripheral bus controller.
package periph_bus_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } bus_state_t;

  localparam int          PAGE_W       = 16;
  localparam logic [31:0] ERR_DATA_DEF = 32'h6666_6666;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/periph_bus_if.sv
// CPU-side memory handshake of the FemtoRV32 core.
interface periph_bus_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;

  modport master (output mem_addr, mem_rstrb, mem_wmask,
                  input  mem_rdata, mem_rbusy, mem_wbusy);
  modport slave  (input  mem_addr, mem_rstrb, mem_wmask,
                  output mem_rdata, mem_rbusy, mem_wbusy);
endinterface

// File: rtl/bus_addr_decode.sv
// Page decoder: mem_addr[31:16] page to one-hot chip select and slave index.
module bus_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int                NUM_SLAVES = 7,
  parameter logic [PAGE_W-1:0] BASE_PAGE  = 16'h0040,
  parameter int                IDX_W      = 3
) (
  input  logic [PAGE_W-1:0]     page,
  output logic [NUM_SLAVES-1:0] cs,
  output logic [IDX_W-1:0]      idx
);
  logic [PAGE_W-1:0] offset;

  always_comb begin
    idx    = '0;
    offset = page - BASE_PAGE;
    // Anything outside the peripheral window falls through to RAM (slave 0).
    if (page >= BASE_PAGE && offset < PAGE_W'(NUM_SLAVES - 1))
      idx = IDX_W'(offset + 16'd1);
    cs = NUM_SLAVES'(1) << idx;
  end
endmodule

// File: rtl/periph_bus_ctrl.sv
// CPU-to-peripheral bus controller: page decode, wait states, busy, timeout.
// Optional BUS_STATS_EN adds completion / timeout counters.
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int                     NUM_SLAVES  = 7,
  parameter logic [PAGE_W-1:0]      BASE_PAGE   = 16'h0040,
  parameter logic [4*NUM_SLAVES-1:0] WAIT_STATES = {NUM_SLAVES{4'd0}},
  parameter logic [NUM_SLAVES-1:0]  PASS_MASK   = NUM_SLAVES'(1),
  parameter logic [7:0]             TIMEOUT     = 8'd255,
  parameter logic [31:0]            ERR_DATA    = ERR_DATA_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  periph_bus_if.slave                cpu,
  output logic [NUM_SLAVES-1:0]      slv_cs,
  output logic                       slv_rd,
  output logic                       slv_wr,
  output logic [3:0]                 slv_wmask,
  input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
  input  logic [NUM_SLAVES-1:0]      slv_busy,
  output logic                       bus_err,
  input  logic                       err_clr,
  output logic [31:0]                err_addr,
  output logic [31:0]                stat_acc,
  output logic [15:0]                stat_err
);
  // state     | meaning
  // ST_IDLE   | waiting for a request; zero-wait accesses complete here
  // ST_ACCESS | waiting for wait states / slave busy, or timeout

  localparam int IDX_W = clog2(NUM_SLAVES);

  bus_state_t            state, state_nxt;
  logic [NUM_SLAVES-1:0] dec_cs, cs_q;
  logic [IDX_W-1:0]      dec_idx, sel_q, sel;
  logic [31:0]           addr_q, rdata_q;
  logic [7:0]            wcnt;
  logic                  wr_q, pass_q;
  logic                  req, is_wr, cur_wr, done, tmo, rbusy, wbusy;
  logic [3:0]            ws_sel;

  bus_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .BASE_PAGE(BASE_PAGE), .IDX_W(IDX_W)) u_dec (
    .page (cpu.mem_addr[31:16]),
    .cs   (dec_cs),
    .idx  (dec_idx)
  );

  assign req    = cpu.mem_rstrb | (|cpu.mem_wmask);
  assign is_wr  = |cpu.mem_wmask;
  assign sel    = (state == ST_IDLE) ? dec_idx : sel_q;
  assign cur_wr = (state == ST_IDLE) ? is_wr : wr_q;
  assign ws_sel = WAIT_STATES[4*sel +: 4];

  always_comb begin
    state_nxt = state;
    slv_cs    = '0;
    slv_rd    = 1'b0;
    slv_wr    = 1'b0;
    slv_wmask = 4'd0;
    rbusy     = 1'b0;
    wbusy     = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          slv_cs    = dec_cs;
          slv_rd    = ~is_wr;
          slv_wr    = is_wr;
          slv_wmask = cpu.mem_wmask;
          if (ws_sel == 4'd0 && !slv_busy[sel]) begin
            done = 1'b1;
          end else begin
            state_nxt = ST_ACCESS;
            rbusy     = ~is_wr;
            wbusy     = is_wr;
          end
        end
      end
      ST_ACCESS: begin
        slv_cs = cs_q;
        rbusy  = ~wr_q;
        wbusy  = wr_q;
        if (wcnt >= 8'(ws_sel) && !slv_busy[sel]) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wcnt >= TIMEOUT) begin
          tmo       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cs_q     <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      wcnt     <= '0;
      wr_q     <= 1'b0;
      pass_q   <= 1'b0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req) begin
        addr_q <= cpu.mem_addr;
        cs_q   <= dec_cs;
        sel_q  <= dec_idx;
        wr_q   <= is_wr;
        pass_q <= 1'b0;
        wcnt   <= 8'd1;
      end else if (state == ST_ACCESS && wcnt < TIMEOUT) begin
        wcnt <= wcnt + 8'd1;
      end
      if (done && !cur_wr) begin
        if (PASS_MASK[sel]) pass_q  <= 1'b1;
        else                rdata_q <= slv_rdata[32*sel +: 32];
      end
      if (tmo && !wr_q) rdata_q <= ERR_DATA;
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (tmo) begin
        bus_err  <= 1'b1;
        err_addr <= addr_q;
      end else if (err_clr) begin
        bus_err  <= 1'b0;
      end
    end
  end

  assign cpu.mem_rdata = pass_q ? slv_rdata[32*sel_q +: 32] : rdata_q;
  assign cpu.mem_rbusy = rbusy;
  assign cpu.mem_wbusy = wbusy;

`ifdef BUS_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_acc <= '0;
      stat_err <= '0;
    end else begin
      if (done) stat_acc <= stat_acc + 32'd1;
      if (tmo)  stat_err <= stat_err + 16'd1;
    end
  end
`else
  assign stat_acc = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: decode, wait states, busy, timeout, pass-through.
module tb_periph_bus_ctrl;
  import periph_bus_pkg::*;

`ifdef BUS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   slv_cs, slv_busy;
  logic         slv_rd, slv_wr;
  logic [3:0]   slv_wmask;
  logic [223:0] slv_rdata;
  logic         bus_err, err_clr;
  logic [31:0]  err_addr, stat_acc;
  logic [15:0]  stat_err;
  int           n_cmp = 0;
  int           n_bad = 0;

  periph_bus_if bus();

  periph_bus_ctrl #(
    .NUM_SLAVES  (7),
    .BASE_PAGE   (16'h0040),
    .WAIT_STATES ({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0}),
    .PASS_MASK   (7'b0000001),
    .TIMEOUT     (8'd8),
    .ERR_DATA    (32'h6666_6666)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (bus.slave),
    .slv_cs    (slv_cs),
    .slv_rd    (slv_rd),
    .slv_wr    (slv_wr),
    .slv_wmask (slv_wmask),
    .slv_rdata (slv_rdata),
    .slv_busy  (slv_busy),
    .bus_err   (bus_err),
    .err_clr   (err_clr),
    .err_addr  (err_addr),
    .stat_acc  (stat_acc),
    .stat_err  (stat_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_addr = '0; bus.mem_rstrb = 1'b0; bus.mem_wmask = 4'd0;
    slv_busy = '0; slv_rdata = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    n_cmp++; if (bus.mem_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.mem_rdata); end
    n_cmp++; if (bus.mem_rbusy !== 1'b0 || bus.mem_wbusy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b%b want 00", bus.mem_rbusy, bus.mem_wbusy); end
    n_cmp++; if (slv_cs !== 7'd0) begin n_bad++; $display("FAIL rst_cs: got %b want 0", slv_cs); end
    n_cmp++; if (bus_err !== 1'b0 || err_addr !== 32'd0) begin n_bad++; $display("FAIL rst_err: got %b %h want 0 0", bus_err, err_addr); end
    n_cmp++; if (stat_acc !== 32'd0 || stat_err !== 16'd0) begin n_bad++; $display("FAIL rst_stats: got %0d %0d want 0 0", stat_acc, stat_err); end
    // start a 3-wait-state read and reset in the middle of it
    @(negedge clk); bus.mem_addr = 32'h0040_0000; bus.mem_rstrb = 1'b1;
    @(negedge clk); bus.mem_rstrb = 1'b0; #1;
    n_cmp++; if (bus.mem_rbusy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_access: got %b want 1", bus.mem_rbusy); end
    #1 reset = 1'b1; #1;
    n_cmp++; if (slv_cs !== 7'd0 || bus.mem_rbusy !== 1'b0) begin n_bad++; $display("FAIL rst_async: got cs=%b rbusy=%b want 0 0", slv_cs, bus.mem_rbusy); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.mem_rbusy !== 1'b0 || bus.mem_rdata !== 32'd0 || stat_acc !== 32'd0) begin n_bad++; $display("FAIL rst_idle: got rbusy=%b rdata=%h acc=%0d want 0 0 0", bus.mem_rbusy, bus.mem_rdata, stat_acc); end
  endtask

  task automatic test_zero_wait();
    slv_rdata[32*3 +: 32] = 32'h0000_1234;
    @(negedge clk); bus.mem_addr = 32'h0042_0000; bus.mem_rstrb = 1'b1; #1;
    n_cmp++; if (slv_cs !== 7'b0001000) begin n_bad++; $display("FAIL zw_cs: got %b want 0001000", slv_cs); end
    n_cmp++; if (slv_rd !== 1'b1 || slv_wr !== 1'b0) begin n_bad++; $display("FAIL zw_rdwr: got %b%b want 10", slv_rd, slv_wr); end
    n_cmp++; if (bus.mem_rbusy !== 1'b0) begin n_bad++; $display("FAIL zw_rbusy_n: got %b want 0", bus.mem_rbusy); end
    @(negedge clk); bus.mem_rstrb = 1'b0; #1;
    n_cmp++; if (bus.mem_rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL zw_rdata: got %h want 00001234", bus.mem_rdata); end
    n_cmp++; if (bus.mem_rbusy !== 1'b0 || slv_rd !== 1'b0 || slv_cs !== 7'd0) begin n_bad++; $display("FAIL zw_after: got rbusy=%b rd=%b cs=%b want 0 0 0", bus.mem_rbusy, slv_rd, slv_cs); end
  endtask

  task automatic test_wait_states();
    slv_rdata[32*1 +: 32] = 32'hCAFE_0001;
    @(negedge clk); bus.mem_addr = 32'h0040_0000; bus.mem_rstrb = 1'b1; #1;
    n_cmp++; if (bus.mem_rbusy !== 1'b1 || slv_rd !== 1'b1 || slv_cs !== 7'b0000010) begin n_bad++; $display("FAIL ws_n: got rbusy=%b rd=%b cs=%b want 1 1 0000010", bus.mem_rbusy, slv_rd, slv_cs); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.mem_rstrb = 1'b0;
      // a write request during ACCESS must be ignored
      bus.mem_wmask = (k == 2) ? 4'hF : 4'h0;
      bus.mem_addr  = (k == 2) ? 32'h0043_0000 : 32'h0040_0000;
      #1;
      n_cmp++; if (bus.mem_rbusy !== 1'b1 || slv_rd !== 1'b0 || slv_wr !== 1'b0 || slv_cs !== 7'b0000010) begin n_bad++; $display("FAIL ws_hold%0d: got rbusy=%b rd=%b wr=%b cs=%b want 1 0 0 0000010", k, bus.mem_rbusy, slv_rd, slv_wr, slv_cs); end
    end
    n_cmp++; if (bus.mem_rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL ws_early: got %h want 00001234", bus.mem_rdata); end
    @(negedge clk); bus.mem_wmask = 4'd0; #1;
    n_cmp++; if (bus.mem_rbusy !== 1'b0 || bus.mem_rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL ws_done: got rbusy=%b rdata=%h want 0 cafe0001", bus.mem_rbusy, bus.mem_rdata); end
  endtask

  task automatic test_write_busy();
    slv_busy[4] = 1'b1;
    @(negedge clk); bus.mem_addr = 32'h0043_0000; bus.mem_wmask = 4'b0011; #1;
    n_cmp++; if (bus.mem_wbusy !== 1'b1 || slv_wr !== 1'b1 || slv_rd !== 1'b0) begin n_bad++; $display("FAIL wr_n: got wbusy=%b wr=%b rd=%b want 1 1 0", bus.mem_wbusy, slv_wr, slv_rd); end
    n_cmp++; if (slv_wmask !== 4'b0011 || slv_cs !== 7'b0010000) begin n_bad++; $display("FAIL wr_mask_cs: got %b %b want 0011 0010000", slv_wmask, slv_cs); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.mem_wmask = 4'd0;
      if (k == 5) slv_busy[4] = 1'b0;
      #1;
      n_cmp++; if (bus.mem_wbusy !== 1'b1 || slv_wr !== 1'b0) begin n_bad++; $display("FAIL wr_hold%0d: got wbusy=%b wr=%b want 1 0", k, bus.mem_wbusy, slv_wr); end
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.mem_wbusy !== 1'b0 || slv_cs !== 7'd0) begin n_bad++; $display("FAIL wr_done: got wbusy=%b cs=%b want 0 0", bus.mem_wbusy, slv_cs); end
  endtask

  task automatic test_timeout();
    slv_busy[5] = 1'b1;
    @(negedge clk); bus.mem_addr = 32'h0044_0000; bus.mem_rstrb = 1'b1; #1;
    n_cmp++; if (bus.mem_rbusy !== 1'b1 || slv_cs !== 7'b0100000) begin n_bad++; $display("FAIL to_n: got rbusy=%b cs=%b want 1 0100000", bus.mem_rbusy, slv_cs); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); bus.mem_rstrb = 1'b0; #1;
      n_cmp++; if (bus.mem_rbusy !== 1'b1) begin n_bad++; $display("FAIL to_hold%0d: got %b want 1", k, bus.mem_rbusy); end
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.mem_rbusy !== 1'b0 || bus.mem_rdata !== 32'h6666_6666) begin n_bad++; $display("FAIL to_abort: got rbusy=%b rdata=%h want 0 66666666", bus.mem_rbusy, bus.mem_rdata); end
    n_cmp++; if (bus_err !== 1'b1 || err_addr !== 32'h0044_0000) begin n_bad++; $display("FAIL to_err: got %b %h want 1 00440000", bus_err, err_addr); end
    n_cmp++; if (stat_acc !== (STATS ? 32'd3 : 32'd0) || stat_err !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL to_stats: got %0d %0d want %0d %0d", stat_acc, stat_err, STATS ? 3 : 0, STATS ? 1 : 0); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL to_clr: got %b want 0", bus_err); end
    @(negedge clk); bus.mem_addr = 32'h0044_0010; bus.mem_rstrb = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); bus.mem_rstrb = 1'b0;
      err_clr = (k == 8);
    end
    @(negedge clk); err_clr = 1'b0; #1;
    n_cmp++; if (bus_err !== 1'b1 || err_addr !== 32'h0044_0010) begin n_bad++; $display("FAIL to_setwins: got %b %h want 1 00440010", bus_err, err_addr); end
    slv_busy[5] = 1'b0;
  endtask

  task automatic test_pass_and_range();
    slv_rdata[32*0 +: 32] = 32'hA5A5_0000;
    slv_rdata[32*6 +: 32] = 32'h0000_0606;
    @(negedge clk); bus.mem_addr = 32'h0000_1000; bus.mem_rstrb = 1'b1; #1;
    n_cmp++; if (slv_cs !== 7'b0000001 || bus.mem_rbusy !== 1'b0) begin n_bad++; $display("FAIL ps_n: got cs=%b rbusy=%b want 0000001 0", slv_cs, bus.mem_rbusy); end
    @(negedge clk); bus.mem_rstrb = 1'b0; #1;
    n_cmp++; if (bus.mem_rdata !== 32'hA5A5_0000) begin n_bad++; $display("FAIL ps_rdata: got %h want a5a50000", bus.mem_rdata); end
    slv_rdata[32*0 +: 32] = 32'h0BAD_F00D; #1;
    n_cmp++; if (bus.mem_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL ps_follow: got %h want 0badf00d", bus.mem_rdata); end
    @(negedge clk); bus.mem_addr = 32'h0045_0000; bus.mem_rstrb = 1'b1; #1;
    n_cmp++; if (slv_cs !== 7'b1000000) begin n_bad++; $display("FAIL rg_top: got %b want 1000000", slv_cs); end
    @(negedge clk); bus.mem_rstrb = 1'b0; #1;
    n_cmp++; if (bus.mem_rdata !== 32'h0000_0606) begin n_bad++; $display("FAIL rg_top_data: got %h want 00000606", bus.mem_rdata); end
    @(negedge clk); bus.mem_addr = 32'h0046_0000; bus.mem_rstrb = 1'b1; #1;
    n_cmp++; if (slv_cs !== 7'b0000001) begin n_bad++; $display("FAIL rg_out: got %b want 0000001", slv_cs); end
    @(negedge clk); bus.mem_rstrb = 1'b0; #1;
    n_cmp++; if (stat_acc !== (STATS ? 32'd6 : 32'd0) || stat_err !== (STATS ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL end_stats: got %0d %0d want %0d %0d", stat_acc, stat_err, STATS ? 6 : 0, STATS ? 2 : 0); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_write_busy();
    test_timeout();
    test_pass_and_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
